// File: rtl/conv_result_drain_if.sv
// Result-drain bus: the engine's tile-done side and the output element stream.
// master = the drain block, slave = engine / output-buffer writer side.
interface conv_result_drain_if #(
  parameter int DATA_WIDTH = 16,
  parameter int PARA_X     = 3,
  parameter int PARA_Y     = 3,
  parameter int ADDR_WIDTH = 16
);
  logic                                 result_ready;
  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  result_buffer;
  logic [ADDR_WIDTH-1:0]                base_addr;
  logic                                 conv_clear;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [DATA_WIDTH-1:0]                out_data;
  logic [ADDR_WIDTH-1:0]                out_addr;
  logic                                 out_last;
  logic                                 busy;
  logic                                 overrun;

  modport master (
    input  result_ready, result_buffer, base_addr, out_ready,
    output conv_clear, out_valid, out_data, out_addr, out_last, busy, overrun
  );

  modport slave (
    output result_ready, result_buffer, base_addr, out_ready,
    input  conv_clear, out_valid, out_data, out_addr, out_last, busy, overrun
  );
endinterface

// File: rtl/conv_result_drain.sv
// conv_result_drain: captures the engine's PARA_X*PARA_Y float16 result tile on
// each rising result_ready, pulses conv_clear so the engine restarts, then
// streams the tile one element per valid/ready handshake with base_addr + index.
// Optional build macro RESULT_RELU_EN: zero any output element whose sign bit
// is set (including -0); captured data is untouched, mapping is on the output.
module conv_result_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int PARA_X     = 3,
  parameter int PARA_Y     = 3,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  conv_result_drain_if.master     bus
);
  localparam int N     = PARA_X * PARA_Y;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic                     rdy_d;
  logic                     conv_clear_q;
  logic                     overrun_q;

  logic [N*DATA_WIDTH-1:0]  tile_p0;
  logic [ADDR_WIDTH-1:0]    base_p0;
  logic [DATA_WIDTH-1:0]    elem [N];

  logic                     rise;
  logic                     at_last;
  logic                     xfer;
  logic                     final_xfer;
  logic                     capture;

  // Output element mapping; sign-bit clamp only when the ReLU build is selected.
  function automatic logic [DATA_WIDTH-1:0] relu_map(input logic [DATA_WIDTH-1:0] e);
`ifdef RESULT_RELU_EN
    relu_map = e[DATA_WIDTH-1] ? '0 : e;
`else
    relu_map = e;
`endif
  endfunction

  // Edge detect and handshake qualifiers; a capture is legal from IDLE or on
  // the final transfer so back-to-back tiles drain without a bubble.
  always_comb begin
    rise       = bus.result_ready & ~rdy_d;
    at_last    = (idx == LAST_IDX);
    xfer       = (state == SEND) & bus.out_ready;
    final_xfer = xfer & at_last;
    capture    = rise & ((state == IDLE) | final_xfer);
  end

  // Control FSM: state, element index, edge history, clear pulse, sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      rdy_d        <= 1'b0;
      conv_clear_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rdy_d        <= bus.result_ready;
      conv_clear_q <= capture;
      if (rise && (state == SEND) && !final_xfer) begin
        overrun_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (capture) begin
            state <= SEND;
            idx   <= '0;
          end
        end
        SEND: begin
          if (xfer) begin
            if (at_last) begin
              idx <= '0;
              if (!capture) begin
                state <= IDLE;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Tile and base address capture; data registers carry no reset because the
  // FSM gates every use of them.
  always_ff @(posedge clk) begin
    if (capture) begin
      tile_p0 <= bus.result_buffer;
      base_p0 <= bus.base_addr;
    end
  end

  // Unpack the captured tile into addressable elements.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      elem[k] = tile_p0[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stream outputs derive only from registered state, so they hold steady
  // through any stall; everything reads zero outside SEND.
  always_comb begin
    bus.out_valid  = (state == SEND);
    bus.busy       = (state == SEND);
    bus.out_last   = (state == SEND) & at_last;
    bus.out_data   = (state == SEND) ? relu_map(elem[idx]) : '0;
    bus.out_addr   = (state == SEND) ? (base_p0 + ADDR_WIDTH'(idx)) : '0;
    bus.conv_clear = conv_clear_q;
    bus.overrun    = overrun_q;
  end

endmodule

// File: tb/tb_conv_result_drain.sv
// Directed bench for conv_result_drain: basic drain, backpressure, held level,
// overrun, back-to-back with address wrap, reset mid-drain, ReLU mapping.
module tb_conv_result_drain;
  localparam int DW = 16;
  localparam int PX = 3;
  localparam int PY = 3;
  localparam int AW = 16;
  localparam int N  = PX * PY;

  typedef logic [DW-1:0] tile_t [N];

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  conv_result_drain_if #(.DATA_WIDTH(DW), .PARA_X(PX), .PARA_Y(PY), .ADDR_WIDTH(AW)) bus ();

  conv_result_drain #(.DATA_WIDTH(DW), .PARA_X(PX), .PARA_Y(PY), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  tile_t t1;
  tile_t t2;
  tile_t t6;
  tile_t exp6;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] pack(input tile_t t);
    logic [N*DW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = t[k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise result_ready (caller guarantees it was low at the previous edge).
  task automatic start_tile(input string tag, input tile_t t, input logic [AW-1:0] base);
    bus.result_buffer = pack(t);
    bus.base_addr     = base;
    bus.result_ready  = 1'b1;
    tick();
    check({tag, "_clr"},   bus.conv_clear, 1);
    check({tag, "_valid"}, bus.out_valid,  1);
    check({tag, "_busy"},  bus.busy,       1);
  endtask

  // Drain one tile and compare each transfer; optional events keyed on the
  // index of the element currently presented.
  task automatic drain(input string tag, input tile_t exp, input logic [AW-1:0] base,
                       input int bp, input int ev_low, input int ev_high,
                       input int ev_b2b, input tile_t t_next, input logic [AW-1:0] base_next,
                       input int ev_rst);
    int got;
    int phase;
    bit stall;
    bit rdy;
    logic [DW-1:0] hd;
    logic [AW-1:0] ha;
    logic hl;
    got = 0; phase = 0; stall = 0; hd = '0; ha = '0; hl = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (got == N) break;
      if (ev_rst == got) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        return;
      end
      if (cyc == 1) check({tag, "_clr_once"}, bus.conv_clear, 0);
      if (bus.out_valid) begin
        if (stall) begin
          check($sformatf("%s_hold_d%0d", tag, got), bus.out_data, hd);
          check($sformatf("%s_hold_a%0d", tag, got), bus.out_addr, ha);
          check($sformatf("%s_hold_l%0d", tag, got), bus.out_last, hl);
        end
        if (got == ev_low)  bus.result_ready = 1'b0;
        if (got == ev_high) bus.result_ready = 1'b1;
        if (ev_b2b != 0 && got == N - 1) begin
          bus.result_buffer = pack(t_next);
          bus.base_addr     = base_next;
          bus.result_ready  = 1'b1;
        end
        rdy = (bp == 0) || (phase % 3 == 0);
        phase++;
        bus.out_ready = rdy;
        if (rdy) begin
          check($sformatf("%s_data%0d", tag, got), bus.out_data, exp[got]);
          check($sformatf("%s_addr%0d", tag, got), bus.out_addr, 16'(base + got));
          check($sformatf("%s_last%0d", tag, got), bus.out_last, (got == N - 1));
          got++;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          hd = bus.out_data;
          ha = bus.out_addr;
          hl = bus.out_last;
        end
      end
      tick();
    end
    if (got < N) check({tag, "_timeout"}, got, N);
    bus.out_ready = 1'b1;
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_valid0"}, bus.out_valid, 0);
    check({tag, "_busy0"},  bus.busy,      0);
    check({tag, "_last0"},  bus.out_last,  0);
  endtask

  initial begin
    // Tile 1, element k listed LSB first (MSB-first list was 4000..0000).
    t1[0] = 16'h0000; t1[1] = 16'h0000; t1[2] = 16'h0000;
    t1[3] = 16'h4d00; t1[4] = 16'h4900; t1[5] = 16'h4400;
    t1[6] = 16'h4f80; t1[7] = 16'h4dc0; t1[8] = 16'h4000;
    for (int k = 0; k < N; k++) t2[k] = 16'h3c00;
    for (int k = 0; k < N; k++) t6[k] = 16'h3c00;
    t6[0] = 16'hc000; t6[1] = 16'h8000; t6[2] = 16'h4200;
    exp6 = t6;
`ifdef RESULT_RELU_EN
    exp6[0] = 16'h0000; exp6[1] = 16'h0000;
`endif

    rst = 1'b1;
    bus.result_ready  = 1'b0;
    bus.result_buffer = '0;
    bus.base_addr     = '0;
    bus.out_ready     = 1'b1;
    tick();
    tick();
    expect_idle("rst");
    check("rst_clr",     bus.conv_clear, 0);
    check("rst_overrun", bus.overrun,    0);
    check("rst_data",    bus.out_data,   0);
    check("rst_addr",    bus.out_addr,   0);
    rst = 1'b0;
    tick();
    expect_idle("post_rst");

    // 1. Basic drain
    start_tile("basic", t1, 16'h0100);
    bus.result_ready = 1'b0;
    drain("basic", t1, 16'h0100, 0, -1, -1, 0, t2, 16'h0000, -1);
    expect_idle("basic_end");

    // 2. Backpressure 1,0,0,1,...
    tick();
    start_tile("bp", t1, 16'h0100);
    bus.result_ready = 1'b0;
    drain("bp", t1, 16'h0100, 1, -1, -1, 0, t2, 16'h0000, -1);
    expect_idle("bp_end");

    // 3a. Level held high through drain: single capture only
    tick();
    start_tile("held", t1, 16'h0100);
    drain("held", t1, 16'h0100, 0, -1, -1, 0, t2, 16'h0000, -1);
    expect_idle("held_end");
    tick();
    tick();
    check("held_valid_later", bus.out_valid, 0);
    check("held_overrun",     bus.overrun,   0);
    bus.result_ready = 1'b0;
    tick();

    // 4. Back-to-back with address wrap
    start_tile("b2b1", t1, 16'h0100);
    bus.result_ready = 1'b0;
    drain("b2b1", t1, 16'h0100, 0, -1, -1, 1, t2, 16'hfffc, -1);
    check("b2b_nogap",   bus.out_valid,  1);
    check("b2b_clr",     bus.conv_clear, 1);
    check("b2b_addr0",   bus.out_addr,   16'hfffc);
    check("b2b_overrun", bus.overrun,    0);
    drain("b2b2", t2, 16'hfffc, 0, -1, -1, 0, t2, 16'h0000, -1);
    expect_idle("b2b_end");
    bus.result_ready = 1'b0;
    tick();

    // 3b. Re-raise during drain sets sticky overrun, current tile unaffected
    start_tile("ovr", t1, 16'h0200);
    bus.result_buffer = pack(t2);
    drain("ovr", t1, 16'h0200, 0, 1, 3, 0, t2, 16'h0000, -1);
    check("ovr_flag", bus.overrun, 1);
    expect_idle("ovr_end");
    tick();
    check("ovr_sticky",    bus.overrun,   1);
    check("ovr_no_second", bus.out_valid, 0);
    bus.result_ready = 1'b0;
    tick();

    // 5. Reset mid-drain at element 4
    start_tile("rmd", t1, 16'h0300);
    bus.result_ready = 1'b0;
    drain("rmd", t1, 16'h0300, 0, -1, -1, 0, t2, 16'h0000, 4);
    expect_idle("rmd_rst");
    check("rmd_overrun", bus.overrun,    0);
    check("rmd_clr",     bus.conv_clear, 0);
    check("rmd_data",    bus.out_data,   0);
    check("rmd_addr",    bus.out_addr,   0);
    tick();
    check("rmd_quiet", bus.out_valid, 0);
    start_tile("rmd2", t1, 16'h0300);
    bus.result_ready = 1'b0;
    drain("rmd2", t1, 16'h0300, 0, -1, -1, 0, t2, 16'h0000, -1);
    expect_idle("rmd2_end");

    // 6. Sign-bit elements (ReLU mapping depends on build)
    tick();
    start_tile("relu", t6, 16'h0040);
    bus.result_ready = 1'b0;
    drain("relu", exp6, 16'h0040, 0, -1, -1, 0, t2, 16'h0000, -1);
    expect_idle("relu_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_result_drain.md
Name: conv_result_drain

Overview:
- Sits downstream of the ConvParaScaleFloat16 engine and reads its output side. It is the consumer counterpart to the stimulus side that feeds input_data and weight.
- On each new result_ready it captures the PARA_X*PARA_Y float16 result tile and pulses conv_clear so the engine restarts.
- It then streams the tile one element per handshake, with a write address, to the output buffer writer.

Parameters:
DATA_WIDTH, 16, element width (float16)
PARA_X, 3, tile width
PARA_Y, 3, tile height
ADDR_WIDTH, 16, output address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
result_ready  in  1  engine tile-done level
result_buffer  in  PARA_X*PARA_Y*DATA_WIDTH  engine tile; element k = bits [k*DATA_WIDTH +: DATA_WIDTH]
base_addr  in  ADDR_WIDTH  address of element 0, sampled at capture
conv_clear  out  1  one-cycle pulse: engine may drop result_ready and restart
out_valid  out  1  out_data/out_addr valid
out_ready  in  1  downstream accept
out_data  out  DATA_WIDTH  tile element
out_addr  out  ADDR_WIDTH  base + element index
out_last  out  1  high with element N-1 (N = PARA_X*PARA_Y)
busy  out  1  high in SEND
overrun  out  1  sticky: new tile arrived while still draining

Behaviour:
- Reset values:
  - Outputs: out_valid, conv_clear, busy, overrun, out_last = 0; out_data, out_addr = 0.
  - Internal: idx = 0; rdy_d (previous result_ready) = 0; state = IDLE.
- Edge detect: rise = result_ready & ~rdy_d, where rdy_d is registered every cycle.
  - A level held high never re-captures.
- IDLE state:
  - If rise is seen at edge T, capture result_buffer and base_addr into registers.
  - Set idx = 0 and go to SEND.
  - From T+1: conv_clear = 1 for exactly one cycle; out_valid = 1.
- SEND state:
  - out_valid = 1 and busy = 1.
  - out_data = tile[idx] and out_addr = base_q + idx, modulo 2^ADDR_WIDTH (wrap allowed).
  - out_last = (idx == N-1).
- Handshake rules:
  - A transfer occurs when out_valid & out_ready.
  - out_data, out_addr and out_last stay stable while out_valid & ~out_ready.
  - On transfer with idx < N-1, idx increments.
  - On transfer with idx == N-1, go to IDLE and drop out_valid next cycle.
- Back-to-back: if a rise coincides with the final transfer, capture the new tile.
  - Stay in SEND with idx = 0, so out_valid stays high with no bubble.
  - conv_clear pulses on the next cycle.
- Overrun: a rise in SEND other than on the final-transfer cycle sets overrun.
  - That tile is discarded; the current drain is unaffected.
  - overrun clears only on rst.
- Throughput: N elements in N cycles when out_ready is held high.
  - First element is valid 1 cycle after the rise is sampled.
- Reset mid-drain: abandon the tile, return to reset values, no further outputs.
- rst overrides every other event.

Optional Feature:
RESULT_RELU_EN
- Defined: out_data is forced to 16'h0000 when the selected element's sign bit (bit DATA_WIDTH-1) is 1, which includes -0 (16'h8000). Captured registers are unchanged and the mapping is combinational on output (no extra latency).
- Undefined: out_data passes the element unchanged.

Test Plan:
1. Basic drain:
   - Stimulus: base_addr = 0x0100, out_ready = 1; result_buffer = {4000,4dc0,4f80,4400,4900,4d00,0000,0000,0000} (MSB first); raise result_ready.
   - Required: conv_clear pulses 1 cycle at T+1.
   - Required: out_data sequence 0000,0000,0000,4d00,4900,4400,4f80,4dc0,4000 at addresses 0x0100..0x0108.
   - Required: out_last only on 4000; busy low afterwards.
2. Backpressure:
   - Stimulus: same tile; out_ready toggles 1,0,0,1,...
   - Required: outputs stable during stalls; same 9 elements in order; no duplicates or drops.
3. Held level and overrun:
   - Stimulus: result_ready held high through the drain → required: no second capture, overrun = 0.
   - Stimulus: drop result_ready, re-raise it at element 3 → required: overrun = 1, remaining elements still from the original tile.
4. Back-to-back:
   - Stimulus: second rise on the final-transfer cycle, with second tile all 3c00 and base_addr 0xFFFC.
   - Required: no out_valid gap; second tile addresses wrap as FFFC,FFFD,FFFE,FFFF,0000..0004.
5. Reset mid-drain:
   - Stimulus: assert rst at element 4.
   - Required: next cycle out_valid = 0, overrun = 0, conv_clear = 0; a new rise then drains from element 0.
6. RESULT_RELU_EN:
   - Stimulus: tile containing C000, 8000 and 4200.
   - Required with macro defined: outputs 0000, 0000, 4200.
   - Required with macro undefined: outputs C000, 8000, 4200.
